sad_min_select: RTL and testbench
=================================

Name: sad_min_select

Overview:
- Sits directly downstream of the PE array, which is sequenced by the ctr unit (en_pe / ctr_word).
- Consumes one final SAD per candidate displacement, in raster order over the full search window.
- Tracks the minimum SAD and its displacement, then presents the winning motion vector for the current 16x16 block with a done pulse.
- Output feeds the motion-vector writeback.

Parameters:
- SAD_WIDTH, 16, width of one candidate SAD (256 pixels x 8 bit max = 65280).
- SEARCH_P, 7, search range ±P; candidates per axis N = 2P+1.
- MV_WIDTH, 5, signed two's-complement width of each motion-vector component.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- blk_start  in  1  one-cycle pulse: new current block, begin new search
- sad_valid  in  1  sad_in holds a final candidate SAD this cycle
- sad_in  in  SAD_WIDTH  candidate SAD, unsigned
- busy  out  1  high while searching (SCAN)
- done  out  1  one-cycle pulse when result becomes valid
- result_valid  out  1  mv_x / mv_y / min_sad valid; held until next blk_start or rst
- mv_x  out  MV_WIDTH  signed horizontal displacement of best candidate
- mv_y  out  MV_WIDTH  signed vertical displacement of best candidate
- min_sad  out  SAD_WIDTH  best SAD
- err  out  1  sticky: sad_valid seen outside SCAN; cleared by blk_start or rst

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered.
- Reset value of every output and internal register is 0; state is IDLE.
- States:
  - IDLE: wait for blk_start.
  - SCAN: accept candidates.
  - DONE: result held.
- Transitions:
  - IDLE -> SCAN on blk_start.
  - SCAN -> DONE on the accepted sad_valid that is candidate number N*N-1.
  - DONE -> SCAN on blk_start.
  - blk_start while in SCAN aborts the search and restarts it from candidate 0; no done pulse is issued for the aborted block.
- On blk_start:
  - Clear the index counters idx_x and idx_y, result_valid and err.
  - Load the internal best SAD with all-ones (2^SAD_WIDTH-1).
  - busy = 1 from the next cycle.
  - sad_valid in the same cycle as blk_start is ignored; it is not counted and does not set err.
- Scan order is raster:
  - idx_x increments on each accepted sad_valid.
  - When idx_x = N-1, idx_x wraps to 0 and idx_y increments.
  - Candidate (idx_x, idx_y) corresponds to displacement (idx_x-P, idx_y-P).
- Compare rule:
  - The best candidate is updated only when sad_in < best (strict).
  - On ties the earliest candidate in raster order wins.
  - A candidate with SAD = all-ones still wins against the initial value only if strictly less, so it never wins. Therefore the first candidate is always stored unconditionally.
- Displacement arithmetic: computed at MV_WIDTH bits signed, (idx - P). Requires MV_WIDTH >= clog2(P+1)+1.
- Latency: if the last candidate is accepted at cycle t, then at t+1:
  - result_valid = 1, done = 1 (for that cycle only), busy = 0.
  - min_sad, mv_x and mv_y already include the last candidate.
- mv_x, mv_y and min_sad change only at the DONE transition. They are stable while result_valid = 1.
- sad_valid while in IDLE or DONE: the sample is dropped and err is set to 1 at the next cycle.
- rst asserted mid-SCAN: all state returns to IDLE with outputs 0 at the next edge. rst has priority over blk_start.
- No backpressure: the upstream PE array drives sad_valid at most once per cycle, and every valid in SCAN is consumed.

Test Plan:
- P=1 (N=3), SADs 50,40,30,20,10,15,25,35,45 -> done one cycle after 9th valid; mv=(0,0); min_sad=10; result_valid held.
- P=1, all nine SADs = 100 -> mv=(-1,-1) (first candidate wins tie); min_sad=100.
- P=7, 225 candidates, all 1000 except index 224 = 3 -> mv=(+7,+7); min_sad=3; busy high for exactly the 225 accepts.
- P=1, blk_start after 4 valids, then a fresh 9-value stream with minimum 7 at candidate 2 -> single done pulse, mv=(+1,-1), min_sad=7; the aborted block leaves no trace.
- sad_valid pulse in IDLE, then blk_start -> err=1 after the pulse, err=0 the cycle after blk_start; blk_start-cycle sad_valid is not counted.
- rst asserted mid-SCAN after 5 valids -> all outputs 0 next cycle; a subsequent full stream produces a correct result.

Source files
------------

// File: rtl/sad_min_select_if.sv
// Candidate-SAD stream in, winning motion vector out, between the PE array and MV writeback.
interface sad_min_select_if #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 5
);
  logic                 blk_start;
  logic                 sad_valid;
  logic [SAD_WIDTH-1:0] sad_in;
  logic                 busy;
  logic                 done;
  logic                 result_valid;
  logic [MV_WIDTH-1:0]  mv_x;
  logic [MV_WIDTH-1:0]  mv_y;
  logic [SAD_WIDTH-1:0] min_sad;
  logic                 err;

  modport master (
    output blk_start, sad_valid, sad_in,
    input  busy, done, result_valid, mv_x, mv_y, min_sad, err
  );

  modport slave (
    input  blk_start, sad_valid, sad_in,
    output busy, done, result_valid, mv_x, mv_y, min_sad, err
  );
endinterface

// File: rtl/sad_min_select.sv
// Minimum-SAD search over a (2P+1)x(2P+1) raster of candidates; reports the best
// displacement as a signed motion vector with a one-cycle done pulse.
module sad_min_select #(
  parameter int SAD_WIDTH = 16,
  parameter int SEARCH_P  = 7,
  parameter int MV_WIDTH  = 5
) (
  input logic               clk,
  input logic               rst,
  sad_min_select_if.slave   bus
);
  localparam int N     = 2 * SEARCH_P + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idxX_q, idxX_d, idxY_q, idxY_d;
  logic [SAD_WIDTH-1:0] bestSad_q, bestSad_d;
  logic [MV_WIDTH-1:0]  bestX_q, bestX_d, bestY_q, bestY_d;
  logic [SAD_WIDTH-1:0] minSad_q, minSad_d;
  logic [MV_WIDTH-1:0]  mvX_q, mvX_d, mvY_q, mvY_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 resultValid_q, resultValid_d;
  logic                 err_q, err_d;

  logic [MV_WIDTH-1:0]  curX, curY;
  logic                 isFirst, isLast, candWins;
  logic [SAD_WIDTH-1:0] winSad;
  logic [MV_WIDTH-1:0]  winX, winY;

  // The first candidate is taken unconditionally so an all-ones SAD still lands.
  always_comb begin
    curX     = MV_WIDTH'(idxX_q) - MV_WIDTH'(SEARCH_P);
    curY     = MV_WIDTH'(idxY_q) - MV_WIDTH'(SEARCH_P);
    isFirst  = (idxX_q == '0) && (idxY_q == '0);
    isLast   = (idxX_q == LAST_IDX) && (idxY_q == LAST_IDX);
    candWins = isFirst || (bus.sad_in < bestSad_q);
    winSad   = candWins ? bus.sad_in : bestSad_q;
    winX     = candWins ? curX : bestX_q;
    winY     = candWins ? curY : bestY_q;
  end

  always_comb begin
    state_d       = state_q;
    idxX_d        = idxX_q;
    idxY_d        = idxY_q;
    bestSad_d     = bestSad_q;
    bestX_d       = bestX_q;
    bestY_d       = bestY_q;
    minSad_d      = minSad_q;
    mvX_d         = mvX_q;
    mvY_d         = mvY_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    resultValid_d = resultValid_q;
    err_d         = err_q;

    if (bus.blk_start) begin
      state_d       = S_SCAN;
      idxX_d        = '0;
      idxY_d        = '0;
      bestSad_d     = '1;
      busy_d        = 1'b1;
      resultValid_d = 1'b0;
      err_d         = 1'b0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (bus.sad_valid) begin
            bestSad_d = winSad;
            bestX_d   = winX;
            bestY_d   = winY;
            if (isLast) begin
              state_d       = S_DONE;
              busy_d        = 1'b0;
              done_d        = 1'b1;
              resultValid_d = 1'b1;
              minSad_d      = winSad;
              mvX_d         = winX;
              mvY_d         = winY;
            end else if (idxX_q == LAST_IDX) begin
              idxX_d = '0;
              idxY_d = idxY_q + IDX_W'(1);
            end else begin
              idxX_d = idxX_q + IDX_W'(1);
            end
          end
        end
        default: begin
          if (bus.sad_valid) err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idxX_q        <= '0;
      idxY_q        <= '0;
      bestSad_q     <= '0;
      bestX_q       <= '0;
      bestY_q       <= '0;
      minSad_q      <= '0;
      mvX_q         <= '0;
      mvY_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      resultValid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idxX_q        <= idxX_d;
      idxY_q        <= idxY_d;
      bestSad_q     <= bestSad_d;
      bestX_q       <= bestX_d;
      bestY_q       <= bestY_d;
      minSad_q      <= minSad_d;
      mvX_q         <= mvX_d;
      mvY_q         <= mvY_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      resultValid_q <= resultValid_d;
      err_q         <= err_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = resultValid_q;
  assign bus.mv_x         = mvX_q;
  assign bus.mv_y         = mvY_q;
  assign bus.min_sad      = minSad_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: one P=1 instance for most scenarios and a
// P=7 instance for the full 225-candidate window.
module tb_sad_min_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sad_min_select_if #(.SAD_WIDTH(16), .MV_WIDTH(5)) b1 ();
  sad_min_select_if #(.SAD_WIDTH(16), .MV_WIDTH(5)) b7 ();

  sad_min_select #(.SAD_WIDTH(16), .SEARCH_P(1), .MV_WIDTH(5)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sad_min_select #(.SAD_WIDTH(16), .SEARCH_P(7), .MV_WIDTH(5)) dut7 (.clk(clk), .rst(rst), .bus(b7));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start1();
    b1.blk_start = 1'b1;
    tick();
    b1.blk_start = 1'b0;
  endtask

  task automatic feed1(input logic [15:0] v);
    b1.sad_valid = 1'b1;
    b1.sad_in    = v;
    tick();
    b1.sad_valid = 1'b0;
  endtask

  task automatic start7();
    b7.blk_start = 1'b1;
    tick();
    b7.blk_start = 1'b0;
  endtask

  task automatic feed7(input logic [15:0] v);
    b7.sad_valid = 1'b1;
    b7.sad_in    = v;
    tick();
    b7.sad_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (b1.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0d expected 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0d expected 0", b1.done); end
    checks++; if (b1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rv: got %0d expected 0", b1.result_valid); end
    checks++; if (b1.mv_x !== 5'd0) begin fails++; $display("[TB] FAIL reset_mvx: got %0d expected 0", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'd0) begin fails++; $display("[TB] FAIL reset_mvy: got %0d expected 0", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd0) begin fails++; $display("[TB] FAIL reset_min: got %0d expected 0", b1.min_sad); end
    checks++; if (b1.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %0d expected 0", b1.err); end
    checks++; if (b7.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy7: got %0d expected 0", b7.busy); end
    checks++; if (b7.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rv7: got %0d expected 0", b7.result_valid); end
    rst = 1'b0;
    tick();
  endtask

  // Minimum 10 sits at candidate 4 = (1,1) -> displacement (0,0).
  task automatic test_basic();
    int v[9];
    v = '{50, 40, 30, 20, 10, 15, 25, 35, 45};
    start1();
    checks++; if (b1.busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_start: got %0d expected 1", b1.busy); end
    checks++; if (b1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_rv_start: got %0d expected 0", b1.result_valid); end
    for (int i = 0; i < 8; i++) feed1(16'(v[i]));
    checks++; if (b1.done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_early: got %0d expected 0", b1.done); end
    feed1(16'(v[8]));
    checks++; if (b1.done !== 1'b1) begin fails++; $display("[TB] FAIL basic_done: got %0d expected 1", b1.done); end
    checks++; if (b1.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_rv: got %0d expected 1", b1.result_valid); end
    checks++; if (b1.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_end: got %0d expected 0", b1.busy); end
    checks++; if (b1.mv_x !== 5'd0) begin fails++; $display("[TB] FAIL basic_mvx: got %0d expected 0", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'd0) begin fails++; $display("[TB] FAIL basic_mvy: got %0d expected 0", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd10) begin fails++; $display("[TB] FAIL basic_min: got %0d expected 10", b1.min_sad); end
    tick();
    checks++; if (b1.done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse: got %0d expected 0", b1.done); end
    checks++; if (b1.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_rv_hold: got %0d expected 1", b1.result_valid); end
    checks++; if (b1.min_sad !== 16'd10) begin fails++; $display("[TB] FAIL basic_min_hold: got %0d expected 10", b1.min_sad); end
  endtask

  // All ties: candidate 0 = (-1,-1) must win, encoded as 5'b11111.
  task automatic test_tie();
    start1();
    checks++; if (b1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL tie_rv_clear: got %0d expected 0", b1.result_valid); end
    for (int i = 0; i < 9; i++) feed1(16'd100);
    checks++; if (b1.done !== 1'b1) begin fails++; $display("[TB] FAIL tie_done: got %0d expected 1", b1.done); end
    checks++; if (b1.mv_x !== 5'h1F) begin fails++; $display("[TB] FAIL tie_mvx: got %0d expected 31", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'h1F) begin fails++; $display("[TB] FAIL tie_mvy: got %0d expected 31", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd100) begin fails++; $display("[TB] FAIL tie_min: got %0d expected 100", b1.min_sad); end
  endtask

  task automatic test_full_window();
    int busyCnt;
    busyCnt = 0;
    start7();
    for (int i = 0; i < 225; i++) begin
      if (b7.busy === 1'b1) busyCnt++;
      feed7((i == 224) ? 16'd3 : 16'd1000);
    end
    checks++; if (busyCnt !== 225) begin fails++; $display("[TB] FAIL p7_busy_count: got %0d expected 225", busyCnt); end
    checks++; if (b7.busy !== 1'b0) begin fails++; $display("[TB] FAIL p7_busy_end: got %0d expected 0", b7.busy); end
    checks++; if (b7.done !== 1'b1) begin fails++; $display("[TB] FAIL p7_done: got %0d expected 1", b7.done); end
    checks++; if (b7.mv_x !== 5'd7) begin fails++; $display("[TB] FAIL p7_mvx: got %0d expected 7", b7.mv_x); end
    checks++; if (b7.mv_y !== 5'd7) begin fails++; $display("[TB] FAIL p7_mvy: got %0d expected 7", b7.mv_y); end
    checks++; if (b7.min_sad !== 16'd3) begin fails++; $display("[TB] FAIL p7_min: got %0d expected 3", b7.min_sad); end
  endtask

  // Aborted block feeds values below the real minimum; any leak would change the result.
  task automatic test_abort();
    int v[9];
    int doneCnt;
    v = '{20, 30, 7, 9, 8, 50, 60, 70, 80};
    doneCnt = 0;
    start1();
    for (int i = 1; i <= 4; i++) feed1(16'(i));
    start1();
    checks++; if (b1.busy !== 1'b1) begin fails++; $display("[TB] FAIL abort_busy: got %0d expected 1", b1.busy); end
    checks++; if (b1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_rv: got %0d expected 0", b1.result_valid); end
    for (int i = 0; i < 9; i++) begin
      feed1(16'(v[i]));
      if (b1.done === 1'b1) doneCnt++;
    end
    tick();
    if (b1.done === 1'b1) doneCnt++;
    checks++; if (doneCnt !== 1) begin fails++; $display("[TB] FAIL abort_done_count: got %0d expected 1", doneCnt); end
    checks++; if (b1.mv_x !== 5'd1) begin fails++; $display("[TB] FAIL abort_mvx: got %0d expected 1", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'h1F) begin fails++; $display("[TB] FAIL abort_mvy: got %0d expected 31", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd7) begin fails++; $display("[TB] FAIL abort_min: got %0d expected 7", b1.min_sad); end
    checks++; if (b1.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL abort_rv_end: got %0d expected 1", b1.result_valid); end
  endtask

  // A sample of 1 rides along with blk_start; if counted it would both win and shift done early.
  task automatic test_err();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b1.err !== 1'b0) begin fails++; $display("[TB] FAIL err_idle_init: got %0d expected 0", b1.err); end
    feed1(16'd5);
    checks++; if (b1.err !== 1'b1) begin fails++; $display("[TB] FAIL err_set_idle: got %0d expected 1", b1.err); end
    checks++; if (b1.busy !== 1'b0) begin fails++; $display("[TB] FAIL err_busy_idle: got %0d expected 0", b1.busy); end
    b1.blk_start = 1'b1;
    b1.sad_valid = 1'b1;
    b1.sad_in    = 16'd1;
    tick();
    b1.blk_start = 1'b0;
    b1.sad_valid = 1'b0;
    checks++; if (b1.err !== 1'b0) begin fails++; $display("[TB] FAIL err_clear: got %0d expected 0", b1.err); end
    checks++; if (b1.busy !== 1'b1) begin fails++; $display("[TB] FAIL err_busy_scan: got %0d expected 1", b1.busy); end
    for (int i = 0; i < 8; i++) feed1(16'(90 - 10 * i));
    checks++; if (b1.done !== 1'b0) begin fails++; $display("[TB] FAIL err_done_early: got %0d expected 0", b1.done); end
    feed1(16'd10);
    checks++; if (b1.done !== 1'b1) begin fails++; $display("[TB] FAIL err_done: got %0d expected 1", b1.done); end
    checks++; if (b1.min_sad !== 16'd10) begin fails++; $display("[TB] FAIL err_min: got %0d expected 10", b1.min_sad); end
    checks++; if (b1.mv_x !== 5'd1) begin fails++; $display("[TB] FAIL err_mvx: got %0d expected 1", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'd1) begin fails++; $display("[TB] FAIL err_mvy: got %0d expected 1", b1.mv_y); end
    feed1(16'd2);
    checks++; if (b1.err !== 1'b1) begin fails++; $display("[TB] FAIL err_set_done: got %0d expected 1", b1.err); end
    checks++; if (b1.min_sad !== 16'd10) begin fails++; $display("[TB] FAIL err_min_stable: got %0d expected 10", b1.min_sad); end
    checks++; if (b1.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL err_rv_hold: got %0d expected 1", b1.result_valid); end
  endtask

  task automatic test_rst_mid_scan();
    int v[9];
    v = '{40, 41, 42, 43, 44, 12, 45, 46, 47};
    start1();
    for (int i = 0; i < 5; i++) feed1(16'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b1.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %0d expected 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin fails++; $display("[TB] FAIL rst_done: got %0d expected 0", b1.done); end
    checks++; if (b1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rv: got %0d expected 0", b1.result_valid); end
    checks++; if (b1.err !== 1'b0) begin fails++; $display("[TB] FAIL rst_err: got %0d expected 0", b1.err); end
    checks++; if (b1.mv_x !== 5'd0) begin fails++; $display("[TB] FAIL rst_mvx: got %0d expected 0", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'd0) begin fails++; $display("[TB] FAIL rst_mvy: got %0d expected 0", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd0) begin fails++; $display("[TB] FAIL rst_min: got %0d expected 0", b1.min_sad); end
    start1();
    for (int i = 0; i < 9; i++) feed1(16'(v[i]));
    checks++; if (b1.done !== 1'b1) begin fails++; $display("[TB] FAIL rst_after_done: got %0d expected 1", b1.done); end
    checks++; if (b1.mv_x !== 5'd1) begin fails++; $display("[TB] FAIL rst_after_mvx: got %0d expected 1", b1.mv_x); end
    checks++; if (b1.mv_y !== 5'd0) begin fails++; $display("[TB] FAIL rst_after_mvy: got %0d expected 0", b1.mv_y); end
    checks++; if (b1.min_sad !== 16'd12) begin fails++; $display("[TB] FAIL rst_after_min: got %0d expected 12", b1.min_sad); end
  endtask

  initial begin
    b1.blk_start = 1'b0;
    b1.sad_valid = 1'b0;
    b1.sad_in    = '0;
    b7.blk_start = 1'b0;
    b7.sad_valid = 1'b0;
    b7.sad_in    = '0;
    test_reset();
    test_basic();
    test_tie();
    test_full_window();
    test_abort();
    test_err();
    test_rst_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
